// File: rtl/mem_arbiter_if.sv
// Bundles the CPU port, loader port, and memory-side bus of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    output ld_rdata, ld_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  ld_rdata, ld_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the CPU
// control path and the boot/debug loader; one transaction at a time, one-cycle ack.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LD  = 1'b1;

  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              owner_q,      owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q,         we_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [DATA_W-1:0] wdata_q,      wdata_d;
  logic              mem_en_q,     mem_en_d;
  logic              mem_we_q,     mem_we_d;
  logic              cpu_ack_q,    cpu_ack_d;
  logic              ld_ack_q,     ld_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q,   ld_rdata_d;
  logic              busy_q;

  logic req_cpu;
  logic req_ld;
  logic grant_ld;

  // A simultaneous rd+wr from the CPU is a request; the write strobe decides direction.
  assign req_cpu = bus.cpu_rd | bus.cpu_wr;
  assign req_ld  = bus.ld_req;

  // On a tie the owner opposite the previous one wins, so grants alternate.
  always_comb begin
    grant_ld = req_ld;
    if (req_cpu && req_ld) begin
      grant_ld = (last_owner_q == OWN_CPU);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    cpu_ack_d    = 1'b0;
    ld_ack_d     = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ld_rdata_d   = ld_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_cpu || req_ld) begin
          if (grant_ld) begin
            owner_d = OWN_LD;
            addr_d  = bus.ld_addr;
            wdata_d = bus.ld_wdata;
            we_d    = bus.ld_we;
          end else begin
            owner_d = OWN_CPU;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
            we_d    = bus.cpu_wr;
          end
          cnt_d    = CNT_W'(MEM_LAT - 1);
          mem_en_d = 1'b1;
          mem_we_d = we_d;
          state_d  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          // Read data is valid on the last access cycle.
          if (!we_q) begin
            if (owner_q == OWN_LD) begin
              ld_rdata_d = bus.mem_rdata;
            end else begin
              cpu_rdata_d = bus.mem_rdata;
            end
          end
          cpu_ack_d = (owner_q == OWN_CPU);
          ld_ack_d  = (owner_q == OWN_LD);
          state_d   = S_DONE;
        end else begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = we_q;
        end
      end

      S_DONE: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_LD;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      ld_ack_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      cpu_ack_q    <= cpu_ack_d;
      ld_ack_q     <= ld_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ld_rdata_q   <= ld_rdata_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.ld_ack    = ld_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ld_rdata  = ld_rdata_q;
  assign bus.busy      = busy_q;

  // Stall follows the live request and drops in the ack cycle.
  assign bus.cpu_stall = req_cpu & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks plus an ack-ordered scoreboard
// of expected owner and read data, against a small behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MEM_LAT  = 2;
  localparam int          ACK_TICK = MEM_LAT + 1;
  localparam int          SPACING  = MEM_LAT + 2;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       own_ld;
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem     [256];
  bit         written [256];
  logic [7:0] ref_mem [256];

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h05:   return 8'h3C;
      8'h01:   return 8'h5A;
      8'h02:   return 8'hC3;
      8'h30:   return 8'hE1;
      default: return a ^ 8'h5A;
    endcase
  endfunction

  // Memory model: contents come from init_val until an address is written.
  assign bus.mem_rdata = written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Advance one cycle and sample at +1; any ack is matched against the scoreboard.
  task automatic tick();
    exp_t       e;
    logic [7:0] got;
    @(posedge clk);
    #1;
    if (bus.cpu_ack || bus.ld_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack: cpu_ack=%0b ld_ack=%0b, required no ack", bus.cpu_ack, bus.ld_ack);
      end else begin
        e = sb.pop_front();
        if ({bus.ld_ack, bus.cpu_ack} !== {e.own_ld, ~e.own_ld}) begin
          errors++;
          $display("FAIL sb_owner: ld_ack/cpu_ack=%b%b, required %b%b", bus.ld_ack, bus.cpu_ack, e.own_ld, ~e.own_ld);
        end else if (e.rd) begin
          got = e.own_ld ? bus.ld_rdata : bus.cpu_rdata;
          checks++;
          if (got !== e.data) begin
            errors++;
            $display("FAIL sb_rdata: owner_ld=%0b got 0x%02h, required 0x%02h", e.own_ld, got, e.data);
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One transaction from a single requester; expectation pushed as stimulus is driven.
  task automatic run_xact(input bit is_ld, input bit rd, input bit wr,
                          input logic [7:0] addr, input logic [7:0] wdata,
                          output int ack_tick, output int en_cyc, output int we_cyc,
                          output bit bus_bad, output bit other_ack);
    exp_t e;
    e.own_ld = is_ld;
    e.rd     = !wr;
    if (wr) begin
      ref_mem[addr] = wdata;
      e.data        = wdata;
    end else begin
      e.data = ref_mem[addr];
    end
    sb.push_back(e);
    if (is_ld) begin
      bus.ld_req   = 1'b1;
      bus.ld_we    = wr;
      bus.ld_addr  = addr;
      bus.ld_wdata = wdata;
    end else begin
      bus.cpu_rd    = rd;
      bus.cpu_wr    = wr;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
    end
    ack_tick  = -1;
    en_cyc    = 0;
    we_cyc    = 0;
    bus_bad   = 1'b0;
    other_ack = 1'b0;
    for (int t = 1; t <= 20 && ack_tick < 0; t++) begin
      tick();
      if (bus.mem_en) begin
        en_cyc++;
        if (bus.mem_addr !== addr) bus_bad = 1'b1;
        if (wr && bus.mem_wdata !== wdata) bus_bad = 1'b1;
      end
      if (bus.mem_we) we_cyc++;
      if (is_ld ? bus.cpu_ack : bus.ld_ack) other_ack = 1'b1;
      if (is_ld ? bus.ld_ack : bus.cpu_ack) ack_tick = t;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({bus.cpu_rdata, bus.cpu_ack, bus.ld_rdata, bus.ld_ack, bus.mem_en, bus.mem_we,
         bus.mem_addr, bus.mem_wdata, bus.busy, bus.cpu_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%0b we=%0b busy=%0b cpu_ack=%0b ld_ack=%0b, required all 0",
               bus.mem_en, bus.mem_we, bus.busy, bus.cpu_ack, bus.ld_ack);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy=%0b, required 0", bus.busy);
    end
  endtask

  task automatic test_cpu_read();
    int ack_t, en_c, we_c;
    bit bad, other;
    run_xact(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, ack_t, en_c, we_c, bad, other);
    checks++;
    if (ack_t !== ACK_TICK) begin errors++; $display("FAIL cpu_read_ack_cycle: %0d, required %0d", ack_t, ACK_TICK); end
    checks++;
    if (en_c !== int'(MEM_LAT) || we_c !== 0) begin
      errors++; $display("FAIL cpu_read_en_cycles: en=%0d we=%0d, required en=%0d we=0", en_c, we_c, MEM_LAT);
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL cpu_read_addr: bus mismatch=%0b, required 0", bad); end
    checks++;
    if (other !== 1'b0) begin errors++; $display("FAIL cpu_read_ld_ack: ld_ack seen=%0b, required 0", other); end
    checks++;
    if (bus.cpu_rdata !== 8'h3C || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cpu_read_hold: cpu_rdata=0x%02h busy=%0b, required 0x3c busy=0", bus.cpu_rdata, bus.busy);
    end
  endtask

  task automatic test_ld_write_readback();
    int ack_t, en_c, we_c;
    bit bad, other;
    run_xact(1'b1, 1'b0, 1'b1, 8'h10, 8'hA5, ack_t, en_c, we_c, bad, other);
    checks++;
    if (ack_t !== ACK_TICK || we_c !== int'(MEM_LAT) || bad !== 1'b0 || other !== 1'b0) begin
      errors++;
      $display("FAIL ld_write: ack=%0d we_cycles=%0d bad=%0b cpu_ack=%0b, required ack=%0d we_cycles=%0d 0 0",
               ack_t, we_c, bad, other, ACK_TICK, MEM_LAT);
    end
    run_xact(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, ack_t, en_c, we_c, bad, other);
    checks++;
    if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL readback_cpu_rdata: 0x%02h, required 0xa5", bus.cpu_rdata); end
    checks++;
    if (bus.ld_rdata !== 8'h00) begin errors++; $display("FAIL readback_ld_rdata_hold: 0x%02h, required 0x00", bus.ld_rdata); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   seq [4];
    int   at  [4];
    int   n;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      e.own_ld = (i % 2 == 1);
      e.rd     = 1'b1;
      e.data   = e.own_ld ? ref_mem[8'h02] : ref_mem[8'h01];
      sb.push_back(e);
    end
    bus.cpu_rd  = 1'b1;
    bus.cpu_addr = 8'h01;
    bus.ld_req  = 1'b1;
    bus.ld_we   = 1'b0;
    bus.ld_addr = 8'h02;
    n = 0;
    for (int t = 1; t <= 40 && n < 4; t++) begin
      tick();
      if (bus.cpu_ack || bus.ld_ack) begin
        seq[n] = int'(bus.ld_ack);
        at[n]  = t;
        n++;
      end
    end
    clear_inputs();
    tick();
    checks++;
    if (n !== 4) begin errors++; $display("FAIL rr_ack_count: %0d, required 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] !== i % 2) begin errors++; $display("FAIL rr_order[%0d]: ld=%0d, required %0d", i, seq[i], i % 2); end
      checks++;
      if (at[i] !== ACK_TICK + i * SPACING) begin
        errors++; $display("FAIL rr_ack_time[%0d]: %0d, required %0d", i, at[i], ACK_TICK + i * SPACING);
      end
    end
  endtask

  task automatic test_stall_hold();
    exp_t e;
    int   ack_t, en_c, we_c;
    bit   addr_bad, stall_bad, stall_ack, other;
    ref_mem[8'h20] = 8'h77;
    e.own_ld = 1'b0;
    e.rd     = 1'b0;
    e.data   = 8'h77;
    sb.push_back(e);
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 8'h20;
    bus.cpu_wdata = 8'h77;
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL stall_on_request: %0b, required 1", bus.cpu_stall); end
    ack_t     = -1;
    addr_bad  = 1'b0;
    stall_bad = 1'b0;
    stall_ack = 1'b1;
    for (int t = 1; t <= 20 && ack_t < 0; t++) begin
      tick();
      if (bus.mem_en && bus.mem_addr !== 8'h20) addr_bad = 1'b1;
      if (bus.cpu_ack) begin
        ack_t     = t;
        stall_ack = bus.cpu_stall;
      end else if (bus.cpu_stall !== 1'b1) begin
        stall_bad = 1'b1;
      end
      if (t == 1) bus.cpu_addr = 8'h21;
    end
    clear_inputs();
    #1;
    checks++;
    if (addr_bad !== 1'b0 || ack_t !== ACK_TICK) begin
      errors++; $display("FAIL hold_addr: addr changed=%0b ack=%0d, required 0 and %0d", addr_bad, ack_t, ACK_TICK);
    end
    checks++;
    if (stall_bad !== 1'b0) begin errors++; $display("FAIL stall_pending: dropped early=%0b, required 0", stall_bad); end
    checks++;
    if (stall_ack !== 1'b0) begin errors++; $display("FAIL stall_at_ack: %0b, required 0", stall_ack); end
    checks++;
    if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL stall_after: %0b, required 0", bus.cpu_stall); end
    tick();
    run_xact(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, ack_t, en_c, we_c, addr_bad, other);
    checks++;
    if (bus.cpu_rdata !== 8'h77) begin errors++; $display("FAIL stall_readback: 0x%02h, required 0x77", bus.cpu_rdata); end
  endtask

  task automatic test_reset_mid_access();
    int ack_t, en_c, we_c;
    bit bad, other;
    bus.ld_req   = 1'b1;
    bus.ld_we    = 1'b1;
    bus.ld_addr  = 8'h30;
    bus.ld_wdata = 8'h99;
    tick();
    checks++;
    if ({bus.mem_en, bus.mem_we} !== 2'b11) begin
      errors++; $display("FAIL mid_access_active: en/we=%b, required 11", {bus.mem_en, bus.mem_we});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL async_abort: en/we/busy=%b, required 000", {bus.mem_en, bus.mem_we, bus.busy});
    end
    checks++;
    if (bus.cpu_rdata !== 8'h00 || bus.ld_rdata !== 8'h00) begin
      errors++; $display("FAIL abort_rdata_clear: cpu=0x%02h ld=0x%02h, required 0x00 0x00", bus.cpu_rdata, bus.ld_rdata);
    end
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.ld_ack, bus.cpu_ack} !== 3'b000) begin
      errors++; $display("FAIL abort_no_ack: busy/ld_ack/cpu_ack=%b, required 000", {bus.busy, bus.ld_ack, bus.cpu_ack});
    end
    run_xact(1'b1, 1'b0, 1'b0, 8'h30, 8'h00, ack_t, en_c, we_c, bad, other);
    checks++;
    if (ack_t !== ACK_TICK || bus.ld_rdata !== 8'hE1) begin
      errors++; $display("FAIL after_abort_read: ack=%0d ld_rdata=0x%02h, required %0d 0xe1", ack_t, bus.ld_rdata, ACK_TICK);
    end
  endtask

  task automatic test_illegal_rdwr();
    int ack_t, en_c, we_c;
    bit bad, other;
    run_xact(1'b0, 1'b1, 1'b1, 8'h07, 8'h11, ack_t, en_c, we_c, bad, other);
    checks++;
    if (we_c !== int'(MEM_LAT) || bad !== 1'b0) begin
      errors++; $display("FAIL illegal_as_write: we_cycles=%0d bad=%0b, required %0d 0", we_c, bad, MEM_LAT);
    end
    run_xact(1'b0, 1'b1, 1'b0, 8'h07, 8'h00, ack_t, en_c, we_c, bad, other);
    checks++;
    if (bus.cpu_rdata !== 8'h11) begin errors++; $display("FAIL illegal_readback: 0x%02h, required 0x11", bus.cpu_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_cpu_read();
    test_ld_write_readback();
    test_round_robin();
    test_stall_hold();
    test_reset_mid_access();
    test_illegal_rdwr();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data memory between two requesters: the processor control path (stateMachine read/write strobes) and a boot/debug loader port.
- Each access is one arbitrated transaction, held for a fixed memory latency, then acknowledged with a one-cycle pulse.
- Exports a stall signal so the control state machine can freeze while its access is pending.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 2, memory access cycles (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- cpu_rd  input  1  CPU read request, held until cpu_ack
- cpu_wr  input  1  CPU write request, held until cpu_ack
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_rdata  output  DATA_W  CPU read data, registered
- cpu_ack  output  1  one-cycle completion pulse to CPU
- cpu_stall  output  1  CPU request pending and not yet acked
- ld_req  input  1  loader request, held until ld_ack
- ld_we  input  1  loader write (1) / read (0)
- ld_addr  input  ADDR_W  loader address
- ld_wdata  input  DATA_W  loader write data
- ld_rdata  output  DATA_W  loader read data, registered
- ld_ack  output  1  one-cycle completion pulse to loader
- mem_en  output  1  memory enable
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid on the last ACCESS cycle
- busy  output  1  state is not IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; last_owner=LD (so CPU wins the first tie); latency counter 0. Reset mid-transaction aborts immediately: mem_en/mem_we drop asynchronously, no ack is issued, and rdata registers are cleared.
- Request decode:
  - cpu_req = cpu_rd | cpu_wr.
  - cpu_rd and cpu_wr together is illegal; it is treated as a write.
- States: IDLE, ACCESS, DONE.
- IDLE: requests are sampled only in this state.
  - One requester active: it is granted.
  - Both active: the owner opposite last_owner is granted (round-robin).
  - At grant: latch owner, addr, wdata and we; load the counter with MEM_LAT-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS: mem_en=1, mem_we=latched we, mem_addr/mem_wdata are the latched values. They stay stable for exactly MEM_LAT cycles, and input changes during ACCESS are ignored.
  - Counter decrements each cycle.
  - At counter=0: on a read, capture mem_rdata into the owner's rdata register. Then go to DONE.
  - On a write, mem_we is high for all MEM_LAT cycles.
- DONE: the owner's ack is 1 for exactly one cycle and mem_en=0. Update last_owner to the owner, then go to IDLE.
- Timing: grant edge at cycle 0 → ack high during cycle MEM_LAT+1. Minimum spacing between transactions is MEM_LAT+2 cycles.
- Handshake: a requester keeps its request and operands stable until it sees ack, and drops the request on the edge that ends DONE. A request still high in the following IDLE cycle is a new transaction.
- rdata hold: each rdata register holds its value until the next read by the same owner. Writes and the other owner's accesses do not change it. ld_rdata and cpu_rdata are independent.
- cpu_stall = cpu_req & ~cpu_ack. This is combinational from the request and the registered ack.
- busy = (state != IDLE).
- Starvation bound: with both requesters continuously active, grants strictly alternate.

Test Plan:
- Reset then CPU read: preload memory addr 0x05=0x3C, MEM_LAT=2; pulse cpu_rd with addr 0x05 → mem_en high for 2 cycles at addr 0x05, cpu_ack on cycle 3, cpu_rdata=0x3C, ld_ack never asserted.
- Loader write then CPU read-back: ld_we=1, addr 0x10, data 0xA5 → mem_we high 2 cycles, ld_ack pulse; then cpu_rd addr 0x10 → cpu_rdata=0xA5; ld_rdata unchanged (0x00).
- Simultaneous requests from reset: cpu_rd (addr 0x01) and ld_req read (addr 0x02) asserted together, both held → CPU is served first, then loader. Continued re-requests alternate CPU/LD/CPU/LD.
- Stall/hold: cpu_wr asserted and cpu_addr changed from 0x20 to 0x21 mid-ACCESS → mem_addr stays 0x20; cpu_stall is 1 from request until the ack cycle, then 0.
- Reset mid-ACCESS: assert rst during the first ACCESS cycle of a write → mem_en/mem_we go 0 immediately, no ack, busy=0. After release, a new request completes normally.
- Illegal cpu_rd=cpu_wr=1 with addr 0x07, data 0x11 → write performed (mem_we=1); a subsequent read of 0x07 returns 0x11.
